// File: rtl/t07_tft_wrqueue.sv
// rtl/t07_tft_wrqueue.sv - TFT write-request queue feeding an SPI/TFT serializer
// Optional ack watchdog enabled by defining T07_TFT_WRQUEUE_TIMEOUT_EN.
module t07_tft_wrqueue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  output logic                     req_ready,
  output logic                     wi,
  output logic [31:0]              address,
  output logic [31:0]              data,
  input  logic                     ack,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          expire;

  // Ready comes from the registered count only; a pop this cycle frees space next cycle.
  assign req_ready = !rst && (count < FULL);
  assign push      = req_valid && req_ready;
  assign pop       = (state == ISSUE) && (ack || expire);
  assign busy      = (state != IDLE) || (count != '0);
  assign address   = (count != '0) ? mem[rd_ptr][63:32] : 32'h0;
  assign data      = (count != '0) ? mem[rd_ptr][31:0]  : 32'h0;

`ifdef T07_TFT_WRQUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  // The head is abandoned on the last watchdog cycle unless ack arrives in that same cycle.
  assign expire = (state == ISSUE) && !ack && (tcnt == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign expire         = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Entry storage: written at the tail on every accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_addr, req_data};
  end

  // Circular pointers and occupancy; pointer width makes wrap modulo DEPTH implicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Issue sequencer: IDLE -> ISSUE (wi held) -> GAP (one idle cycle) -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wi    <= 1'b0;
`ifdef T07_TFT_WRQUEUE_TIMEOUT_EN
      tcnt  <= '0;
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= ISSUE;
            wi    <= 1'b1;
`ifdef T07_TFT_WRQUEUE_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end
        ISSUE: begin
          if (pop) begin
            state <= GAP;
            wi    <= 1'b0;
          end
`ifdef T07_TFT_WRQUEUE_TIMEOUT_EN
          if (expire) err <= 1'b1;
          else if (!ack) tcnt <= tcnt + TW'(1);
`endif
        end
        GAP: begin
          state <= IDLE;
          wi    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          wi    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/t07_tft_wrqueue.md
T07_TFT_WRQUEUE -- requirements
Module: t07_tft_wrqueue

Interface
- REQ-001: Parameter DEPTH, default 4; number of queued write requests; SHALL be a power of two, 2..16.
- REQ-002: Parameter TIMEOUT, default 1024; number of cycles to wait for ack (used only with the Configuration macro).
- REQ-003: clk  input  1  single system clock; all logic SHALL be on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: req_valid  input  1  upstream write request; a push occurs when req_valid && req_ready.
- REQ-006: req_addr  input  32  TFT command/address word for the request.
- REQ-007: req_data  input  32  TFT data word for the request.
- REQ-008: req_ready  output  1  queue can accept a push this cycle.
- REQ-009: wi  output  1  write-indicate to the SPI/TFT serializer.
- REQ-010: address  output  32  head-entry address presented to the serializer.
- REQ-011: data  output  32  head-entry data presented to the serializer.
- REQ-012: ack  input  1  serializer completion; single-cycle pulse.
- REQ-013: busy  output  1  high when the FSM is not IDLE or the queue is non-empty.
- REQ-014: count  output  $clog2(DEPTH)+1  current number of queued entries.
- REQ-015: err  output  1  sticky timeout flag.

Function
- REQ-016: Storage SHALL be a circular FIFO of DEPTH {addr,data} entries with wrapping read/write pointers and a registered count.
- REQ-017: req_ready SHALL be (count < DEPTH), derived from registered state only; a pop in the same cycle SHALL NOT raise req_ready.
- REQ-018: FSM states SHALL be IDLE, ISSUE and GAP.
- REQ-019: IDLE->ISSUE when count != 0; otherwise remain in IDLE.
- REQ-020: In ISSUE, wi=1 and address/data SHALL equal the head entry, held stable until exit.
- REQ-021: ISSUE->GAP on ack=1; the head entry SHALL be popped on that same edge.
- REQ-022: GAP SHALL last exactly one cycle with wi=0, then go to IDLE.
- REQ-023: In IDLE and GAP, wi=0; address/data SHALL still show the head entry (or 0 when empty).
- REQ-024: ack outside ISSUE SHALL be ignored, with no pop and no state change.
- REQ-025: Latency: for a push at edge N into an empty idle queue, count=1 after edge N, and wi=1 after edge N+1.
- REQ-026: Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
- REQ-027: Back-to-back entries SHALL have at least one wi=0 cycle (GAP) between their ISSUE periods.
- REQ-028: Entries SHALL be issued strictly in push order; pointers SHALL wrap modulo DEPTH.
- REQ-029: count SHALL never exceed DEPTH or underflow below 0.

Reset
- REQ-030: While rst=1 at a clock edge, the FSM SHALL enter IDLE, pointers and count SHALL be 0, and err SHALL be 0.
- REQ-031: While in reset, outputs SHALL be wi=0, address=0, data=0, busy=0, count=0 and req_ready=0; req_ready SHALL become 1 on the first cycle after rst falls.
- REQ-032: Reset asserted mid-ISSUE SHALL drop wi=0 on the next edge and discard all queued entries.
- REQ-033: A pending ack in the cycle of reset SHALL be ignored.

Configuration
- REQ-034: Macro T07_TFT_WRQUEUE_TIMEOUT_EN SHALL enable the ack watchdog.
- REQ-035: With the macro, a cycle counter SHALL clear on entering ISSUE.
  - If ack has not arrived after TIMEOUT cycles in ISSUE, the head entry SHALL be popped (dropped).
  - err SHALL be set to 1 and the FSM SHALL go to GAP.
  - err SHALL be cleared only by reset.
- REQ-036: Without the macro, ISSUE SHALL wait for ack indefinitely and err SHALL be tied to 0.

Verification
- REQ-037: Single write: push addr=0x7ABE01D5, data=0xA0BCAA3D.
  - Required: wi=1 two edges after the push, with address/data matching.
  - Required: ack after 40 cycles -> wi=0 for one cycle, count=0, busy=0 one cycle later.
- REQ-038: Fill: push 4 entries 0x1..0x4 with no ack.
  - Required: req_ready=0 and count=4; a 5th req_valid is not accepted.
  - Required: after 4 acks, addresses are issued in order 0x1, 0x2, 0x3, 0x4.
- REQ-039: Wrap and concurrency: 10 pushes interleaved with acks, with pushes coinciding with acks.
  - Required: issue order is preserved, count is correct, pointers wrap without loss.
- REQ-040: Reset mid-ISSUE with count=3, then rst=1 for 1 cycle.
  - Required: wi=0, count=0, busy=0; a later ack is ignored.
- REQ-041: Spurious ack while IDLE and empty -> no state change, count stays 0.
- REQ-042: With T07_TFT_WRQUEUE_TIMEOUT_EN and TIMEOUT=16, push 2 entries and never ack.
  - Required: err=1 after 16 ISSUE cycles and the second entry issues after GAP.
  - Without the macro: wi stays 1 and err=0.
